fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of instr_mem.
- Holds the program counter and drives instr_addr to instr_mem. Captures the combinationally returned instr into an IF/ID pipeline register.
- Presents the captured instruction to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from later stages; a redirect flushes the IF/ID register.

Parameters:
- ADDRESS_WIDTH, 32, width of PC and instr_addr
- DATA_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- fetch_en  input  1  1 = fetch permitted; 0 = hold PC and issue no new instruction
- redirect_valid  input  1  load redirect_target into PC this cycle
- redirect_target  input  ADDRESS_WIDTH  new PC
- instr_addr  output  ADDRESS_WIDTH  address to instr_mem, equal to the current PC (combinational from pc register)
- instr  input  DATA_WIDTH  instruction returned by instr_mem in the same cycle
- id_valid  output  1  IF/ID register holds a valid instruction
- id_ready  input  1  decode accepts the IF/ID contents this cycle
- id_instr  output  DATA_WIDTH  captured instruction
- id_pc  output  ADDRESS_WIDTH  PC of id_instr

Behaviour:
- Reset (rst=1 at posedge):
  - pc <= RESET_PC
  - id_valid <= 0
  - id_instr <= NOP_INSTR (32'h0000_0013)
  - id_pc <= 0
  - rst overrides every other input.
- Definitions:
  - instr_addr = pc at all times.
  - slot_free = !id_valid || id_ready
  - fetch_fire = fetch_en && slot_free && !redirect_valid
- Priority per cycle, highest first:
  1. rst
  2. redirect_valid: pc <= {redirect_target[AW-1:2], 2'b00}; id_valid <= 0. The redirect flushes regardless of id_ready or fetch_en.
  3. fetch_fire: id_instr <= instr; id_pc <= pc; id_valid <= 1; pc <= pc + 4.
  4. Otherwise:
     - If id_valid && id_ready, then id_valid <= 0; PC holds.
     - Otherwise everything holds.
- Latency:
  - Address to id_valid is 1 cycle.
  - Sustained throughput is 1 instruction per cycle while id_ready=1.
- Stall (id_valid=1, id_ready=0):
  - id_instr, id_pc and pc are stable.
  - No instruction is lost or duplicated.
- Handshake rules:
  - id_valid is never deasserted without acceptance, except by redirect or rst.
  - id_instr and id_pc do not change while id_valid && !id_ready.
- Arithmetic:
  - pc + 4 wraps modulo 2^ADDRESS_WIDTH; no overflow flag.
  - pc[1:0] is always 2'b00.
- Out-of-range PC: instr_mem aliases by address slicing. No range check is done in this block.
- Redirect and accept in the same cycle: the current id contents count as consumed; the new target's instruction appears 1 cycle later.
- fetch_en=0 with id_ready=1: the held instruction is drained; id_valid goes to 0 and PC holds.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN
- With the macro defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A redirect with redirect_target[1:0] != 0 still loads the aligned PC.
  - misalign_err pulses high for exactly 1 cycle, the cycle after the redirect.
  - The next fetched instruction is replaced by NOP_INSTR with id_pc set to the aligned target.
- Without the macro: no port; low bits are silently cleared.

Decomposition:
- Shared package core_pkg holds:
  - NOP_INSTR = 32'h0000_0013
  - INSTR_BYTES = 4
  - default RESET_PC constant
  - the pc_t typedef (logic [ADDRESS_WIDTH-1:0])
- One natural sub-module: if_id_reg. It is the valid/ready pipeline register holding id_instr and id_pc, with flush and load inputs.
- PC logic and priority mux stay in fetch_unit.

Test Plan:
- Reset with RESET_PC=32'h100, then fetch_en=1, id_ready=1:
  - instr_addr sequence is 0x100, 0x104, 0x108.
  - id_pc follows 1 cycle later.
  - id_instr matches memory words 64, 65, 66.
- Stall: id_ready=0 for 3 cycles with id_valid=1, id_pc=0x104:
  - id_pc, id_instr and instr_addr (0x108) are stable for all 3 cycles.
  - On release, 0x108 is issued next with no duplicate.
- Redirect to 0x40 while stalled:
  - The next cycle has id_valid=0 and instr_addr=0x40.
  - The cycle after has id_pc=0x40.
- Redirect and rst asserted together: pc=RESET_PC, id_valid=0, id_instr=32'h13.
- Wrap: pc=32'hFFFF_FFFC, fetch fires -> pc becomes 0 and id_pc=32'hFFFF_FFFC.
- FETCH_MISALIGN_TRAP_EN: redirect to 0x42:
  - pc becomes 0x40.
  - misalign_err is a 1-cycle pulse.
  - The next id_instr is 32'h13 with id_pc=0x40.
  - Without the macro, the same redirect gives id_instr = mem[16].

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: instruction constants, default widths and the PC type.
package core_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int INSTR_BYTES           = 4;

  // addi x0, x0, 0 -- the canonical RISC-V no-op
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [DEFAULT_ADDRESS_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef logic [DEFAULT_ADDRESS_WIDTH-1:0] pc_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a valid/ready handshake toward decode.
// flush drops the held entry, load captures a new one; the two are
// mutually exclusive from the fetch side but flush wins if both are seen.
module if_id_reg
  import core_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     load,
  input  logic [DATA_WIDTH-1:0]    load_instr,
  input  logic [ADDRESS_WIDTH-1:0] load_pc,
  input  logic                     ready,
  output logic                     valid,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] pc
);

  logic                     valid_r;
  logic [DATA_WIDTH-1:0]    instr_r;
  logic [ADDRESS_WIDTH-1:0] pc_r;

  // Valid flag: cleared on reset, flush or acceptance; set on load
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Payload: only a load changes it, so data is stable during a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_r <= DATA_WIDTH'(NOP_INSTR);
      pc_r    <= {ADDRESS_WIDTH{1'b0}};
    end else if (load && !flush) begin
      instr_r <= load_instr;
      pc_r    <= load_pc;
    end else begin
      instr_r <= instr_r;
      pc_r    <= pc_r;
    end
  end

  assign valid = valid_r;
  assign instr = instr_r;
  assign pc    = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses instr_mem and feeds the
// IF/ID register. Redirects from later stages override sequential fetch.
// Optional build macro: FETCH_MISALIGN_TRAP_EN adds misalign_err and
// replaces the first instruction after a misaligned redirect with a NOP.
module fetch_unit
  import core_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int                       DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  output logic [ADDRESS_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0]    instr,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [DATA_WIDTH-1:0]    id_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                     misalign_err,
`endif
  output logic [ADDRESS_WIDTH-1:0] id_pc
);

  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK  = ~ADDRESS_WIDTH'(INSTR_BYTES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] PC_INCREMENT = ADDRESS_WIDTH'(INSTR_BYTES);

  logic [ADDRESS_WIDTH-1:0] pc_r;
  logic [ADDRESS_WIDTH-1:0] aligned_target_s;
  logic                     slot_free_s;
  logic                     fetch_fire_s;
  logic [DATA_WIDTH-1:0]    load_instr_s;
  logic                     id_valid_s;

  // Handshake and fetch decision; redirect always suppresses the fetch
  always_comb begin
    aligned_target_s = redirect_target & ALIGN_MASK;
    slot_free_s      = !id_valid_s || id_ready;
    fetch_fire_s     = fetch_en && slot_free_s && !redirect_valid;
  end

  // Program counter: reset, then redirect, then sequential advance (wraps)
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r <= aligned_target_s;
    end else if (fetch_fire_s) begin
      pc_r <= pc_r + PC_INCREMENT;
    end else begin
      pc_r <= pc_r;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_err_r;
  logic nop_pending_r;
  logic redirect_misaligned_s;

  // Detect a redirect whose target carries non-zero low address bits
  always_comb begin
    redirect_misaligned_s = redirect_valid && (redirect_target != aligned_target_s);
  end

  // One-cycle error pulse and a pending flag that NOPs the next fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err_r <= 1'b0;
      nop_pending_r  <= 1'b0;
    end else if (redirect_valid) begin
      misalign_err_r <= redirect_misaligned_s;
      nop_pending_r  <= redirect_misaligned_s;
    end else if (fetch_fire_s) begin
      misalign_err_r <= 1'b0;
      nop_pending_r  <= 1'b0;
    end else begin
      misalign_err_r <= 1'b0;
      nop_pending_r  <= nop_pending_r;
    end
  end

  // Substitute a NOP for the instruction fetched at a misaligned target
  always_comb begin
    if (nop_pending_r) begin
      load_instr_s = DATA_WIDTH'(NOP_INSTR);
    end else begin
      load_instr_s = instr;
    end
  end

  assign misalign_err = misalign_err_r;
`else
  // Fetched instruction passes straight into the IF/ID register
  always_comb begin
    load_instr_s = instr;
  end
`endif

  if_id_reg #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .load       (fetch_fire_s),
    .load_instr (load_instr_s),
    .load_pc    (pc_r),
    .ready      (id_ready),
    .valid      (id_valid_s),
    .instr      (id_instr),
    .pc         (id_pc)
  );

  assign instr_addr = pc_r;
  assign id_valid   = id_valid_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a word-indexed instruction memory.
// Build with +define+FETCH_MISALIGN_TRAP_EN to cover the misalign trap.
module tb_fetch_unit;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_addr;
  logic [31:0] instr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  // Memory aliases by slicing the word index out of the address
  assign instr = mem[instr_addr[11:2]];

  fetch_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'h0000_0100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_addr      (instr_addr),
    .instr           (instr),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_err    (misalign_err),
`endif
    .id_pc           (id_pc)
  );

  function automatic logic [31:0] word(input int idx);
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pc_t wrap_pc;
    wrap_pc = 32'hFFFF_FFFC;
    for (int i = 0; i < 1024; i++) mem[i] = word(i);

    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; id_ready = 1'b0;
    #2;
    tick();
    check_eq("rst_pc",       64'(instr_addr), 64'h100);
    check_eq("rst_valid",    64'(id_valid),   64'h0);
    check_eq("rst_instr",    64'(id_instr),   64'h13);
    check_eq("rst_id_pc",    64'(id_pc),      64'h0);

    // Sequential fetch at full throughput
    rst = 1'b0; fetch_en = 1'b1; id_ready = 1'b1;
    tick();
    check_eq("seq0_addr",  64'(instr_addr), 64'h104);
    check_eq("seq0_valid", 64'(id_valid),   64'h1);
    check_eq("seq0_pc",    64'(id_pc),      64'h100);
    check_eq("seq0_instr", 64'(id_instr),   64'(word(64)));
    tick();
    check_eq("seq1_addr",  64'(instr_addr), 64'h108);
    check_eq("seq1_pc",    64'(id_pc),      64'h104);
    check_eq("seq1_instr", 64'(id_instr),   64'(word(65)));

    // Decode stalls for three cycles: everything holds
    id_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("stall_valid", 64'(id_valid),   64'h1);
      check_eq("stall_pc",    64'(id_pc),      64'h104);
      check_eq("stall_instr", 64'(id_instr),   64'(word(65)));
      check_eq("stall_addr",  64'(instr_addr), 64'h108);
    end
    id_ready = 1'b1;
    tick();
    check_eq("release_pc",    64'(id_pc),      64'h108);
    check_eq("release_instr", 64'(id_instr),   64'(word(66)));
    check_eq("release_addr",  64'(instr_addr), 64'h10C);

    // Stall, then redirect to 0x40 while stalled
    id_ready = 1'b0;
    tick();
    check_eq("stall2_pc", 64'(id_pc), 64'h108);
    redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    check_eq("redir_valid", 64'(id_valid),   64'h0);
    check_eq("redir_addr",  64'(instr_addr), 64'h40);
    redirect_valid = 1'b0; id_ready = 1'b1;
    tick();
    check_eq("redir_id_pc", 64'(id_pc),    64'h40);
    check_eq("redir_instr", 64'(id_instr), 64'(word(16)));

    // Redirect coinciding with acceptance
    redirect_valid = 1'b1; redirect_target = 32'h200;
    tick();
    check_eq("redacc_valid", 64'(id_valid),   64'h0);
    check_eq("redacc_addr",  64'(instr_addr), 64'h200);
    redirect_valid = 1'b0;
    tick();
    check_eq("redacc_id_pc", 64'(id_pc),    64'h200);
    check_eq("redacc_instr", 64'(id_instr), 64'(word(128)));

    // fetch_en low drains the held entry and holds PC
    fetch_en = 1'b0;
    tick();
    check_eq("drain_valid", 64'(id_valid),   64'h0);
    check_eq("drain_addr",  64'(instr_addr), 64'h204);
    tick();
    check_eq("idle_addr",   64'(instr_addr), 64'h204);

    // PC wraps past the top of the address space
    fetch_en = 1'b1; redirect_valid = 1'b1; redirect_target = wrap_pc;
    tick();
    check_eq("wrap_pre_addr", 64'(instr_addr), 64'hFFFF_FFFC);
    redirect_valid = 1'b0;
    tick();
    check_eq("wrap_addr",  64'(instr_addr), 64'h0);
    check_eq("wrap_id_pc", 64'(id_pc),      64'hFFFF_FFFC);
    check_eq("wrap_instr", 64'(id_instr),   64'(word(1023)));

    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_target = 32'h42;
    tick();
    check_eq("mis_addr",  64'(instr_addr), 64'h40);
    check_eq("mis_valid", 64'(id_valid),   64'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("mis_err_hi", 64'(misalign_err), 64'h1);
`endif
    redirect_valid = 1'b0;
    tick();
    check_eq("mis_id_pc", 64'(id_pc), 64'h40);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("mis_instr_nop", 64'(id_instr),     64'h13);
    check_eq("mis_err_lo",    64'(misalign_err), 64'h0);
`else
    check_eq("mis_instr", 64'(id_instr), 64'(word(16)));
`endif
    tick();
    check_eq("mis_next_pc",    64'(id_pc),    64'h44);
    check_eq("mis_next_instr", 64'(id_instr), 64'(word(17)));

    // Reset dominates a simultaneous redirect
    rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h300;
    tick();
    check_eq("rstred_addr",  64'(instr_addr), 64'h100);
    check_eq("rstred_valid", 64'(id_valid),   64'h0);
    check_eq("rstred_instr", 64'(id_instr),   64'h13);
    check_eq("rstred_id_pc", 64'(id_pc),      64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
